// File: rtl/psum_accum_pkg.sv
// Shared widths and FSM encoding for the partial-sum accumulator.
package psum_accum_pkg;
   localparam int DATA_INTER_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } state_t;
endpackage

// File: rtl/psum_buf.sv
// Simple dual-port column buffer: one write port, one registered read port.
module psum_buf #(
   parameter int WIDTH  = 96,
   parameter int DEPTH  = 224,
   parameter int ADDR_W = 8
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [WIDTH-1:0]  i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [WIDTH-1:0]  o_rdata
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // Read returns the pre-write contents; the accumulator forwards around it.
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/psum_accum.sv
// Accumulates three conv row streams per column across multiple passes;
// pass 0 overwrites the buffer, the final pass emits saturated sums.
module psum_accum
   import psum_accum_pkg::*;
#(
   parameter int DATA_W = DATA_INTER_WIDTH,
   parameter int DEPTH  = 224,
   parameter int ADDR_W = 8,
   parameter int PASS_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [ADDR_W:0]   i_cfg_row_len,
   input  logic [PASS_W-1:0] i_cfg_num_pass,
   input  logic [DATA_W-1:0] i_in_data_1,
   input  logic [DATA_W-1:0] i_in_data_2,
   input  logic [DATA_W-1:0] i_in_data_3,
   input  logic              i_in_valid,
   output logic [DATA_W-1:0] o_out_data_1,
   output logic [DATA_W-1:0] o_out_data_2,
   output logic [DATA_W-1:0] o_out_data_3,
   output logic              o_out_valid,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);
   function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] s;
      s = a + b;
      if ((a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]))
         s = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      return s;
   endfunction

   state_t                  r_state;
   logic [ADDR_W:0]         r_row_len;
   logic [PASS_W-1:0]       r_num_pass, r_pass;
   logic [ADDR_W-1:0]       r_col, r_s0_col;
   logic                    r_drain, r_busy, r_done, r_err, r_out_valid;
   logic                    r_s0_vld, r_s0_first, r_s0_final, r_fwd;
   logic [2:0][DATA_W-1:0]  r_s0_data, r_fwd_data, r_out;
   logic [2:0][DATA_W-1:0]  w_in, w_rd, w_old, w_new;
   logic                    w_last_col, w_last_pass, w_cfg_ok;

   assign w_in        = {i_in_data_3, i_in_data_2, i_in_data_1};
   assign w_last_col  = ({1'b0, r_col} == (r_row_len - (ADDR_W+1)'(1)));
   assign w_last_pass = (r_pass == (r_num_pass - PASS_W'(1)));
   assign w_cfg_ok    = (i_cfg_row_len != '0) && (i_cfg_row_len <= (ADDR_W+1)'(DEPTH));

   psum_buf #(.WIDTH(3*DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_buf (
      .i_clk   (i_clk),
      .i_we    (r_s0_vld),
      .i_waddr (r_s0_col),
      .i_wdata (w_new),
      .i_raddr (r_col),
      .o_rdata (w_rd)
   );

   // S1 lanes: a back-to-back beat to the same column takes the forwarded sum.
   for (genvar l = 0; l < 3; l++) begin : g_lane
      assign w_old[l] = r_fwd ? r_fwd_data[l] : w_rd[l];
      assign w_new[l] = r_s0_first ? r_s0_data[l] : sat_add(w_old[l], r_s0_data[l]);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_row_len   <= '0;
         r_num_pass  <= '0;
         r_pass      <= '0;
         r_col       <= '0;
         r_drain     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out       <= '0;
         r_s0_vld    <= 1'b0;
         r_s0_col    <= '0;
         r_s0_first  <= 1'b0;
         r_s0_final  <= 1'b0;
         r_s0_data   <= '0;
         r_fwd       <= 1'b0;
         r_fwd_data  <= '0;
      end else begin
         r_err      <= 1'b0;
         r_done     <= 1'b0;
         r_s0_vld   <= 1'b0;
         r_fwd      <= r_s0_vld && (r_s0_col == r_col);
         r_fwd_data <= w_new;
         if (r_s0_vld && r_s0_final) begin
            r_out       <= w_new;
            r_out_valid <= 1'b1;
         end else begin
            r_out_valid <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (i_in_valid) r_err <= 1'b1;
               if (i_start) begin
                  if (w_cfg_ok) begin
                     r_row_len  <= i_cfg_row_len;
                     r_num_pass <= (i_cfg_num_pass == '0) ? PASS_W'(1) : i_cfg_num_pass;
                     r_col      <= '0;
                     r_pass     <= '0;
                     r_busy     <= 1'b1;
                     r_state    <= ACCUM;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            ACCUM: begin
               if (i_in_valid) begin
                  r_s0_vld   <= 1'b1;
                  r_s0_col   <= r_col;
                  r_s0_data  <= w_in;
                  r_s0_first <= (r_pass == '0);
                  r_s0_final <= w_last_pass;
                  if (w_last_col) begin
                     r_col  <= '0;
                     r_pass <= r_pass + PASS_W'(1);
                     if (w_last_pass) begin
                        r_drain <= 1'b0;
                        r_state <= DRAIN;
                     end
                  end else begin
                     r_col <= r_col + ADDR_W'(1);
                  end
               end
            end
            DRAIN: begin
               if (i_in_valid) r_err <= 1'b1;
               if (r_drain) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_drain <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_out_data_1 = r_out[0];
   assign o_out_data_2 = r_out[1];
   assign o_out_data_3 = r_out[2];
   assign o_out_valid  = r_out_valid;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_err        = r_err;
endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum (DEPTH=8, DATA_W=32).
module tb_psum_accum;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [3:0]    row_len = '0;
   logic [7:0]    num_pass = '0;
   logic [DW-1:0] d1 = '0, d2 = '0, d3 = '0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] o1, o2, o3;
   logic          out_valid, busy, done, err;

   int n_tests = 0, n_fail = 0;
   int n_done = 0, n_err = 0;
   logic [3*DW-1:0] q [$];

   psum_accum #(.DATA_W(DW), .DEPTH(8), .ADDR_W(3), .PASS_W(8)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .i_cfg_row_len(row_len), .i_cfg_num_pass(num_pass),
      .i_in_data_1(d1), .i_in_data_2(d2), .i_in_data_3(d3), .i_in_valid(in_valid),
      .o_out_data_1(o1), .o_out_data_2(o2), .o_out_data_3(o3), .o_out_valid(out_valid),
      .o_busy(busy), .o_done(done), .o_err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (out_valid) q.push_back({o3, o2, o1});
      if (done) n_done++;
      if (err) n_err++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_job(input logic [3:0] len, input logic [7:0] np);
      start = 1'b1; row_len = len; num_pass = np;
      tick();
      start = 1'b0;
   endtask

   task automatic beat(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
      in_valid = 1'b1; d1 = a; d2 = b; d3 = c;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int d0;
      d0 = n_done;
      for (int i = 0; i < 30 && n_done == d0; i++) tick();
      chk(tag, n_done - d0, 1);
   endtask

   task automatic chk_q(input string tag, input int idx,
                        input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
      logic [3*DW-1:0] e;
      e = (idx < q.size()) ? q[idx] : 'x;
      chk({tag, "_l1"}, e[DW-1:0], a);
      chk({tag, "_l2"}, e[2*DW-1:DW], b);
      chk({tag, "_l3"}, e[3*DW-1:2*DW], c);
   endtask

   initial begin
      int d0, e0;

      // Reset state
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_data1", o1, 0);

      // 1: single pass, output at t+2, done at t+3
      q.delete(); d0 = n_done;
      start_job(4, 1);
      chk("t1_busy", busy, 1);
      beat(1, 10, -1);
      chk("t1_lat_early", out_valid, 0);
      beat(2, 20, -2);
      chk("t1_lat_valid", out_valid, 1);
      chk("t1_lat_data", o1, 1);
      beat(3, 30, -3);
      beat(4, 40, -4);
      tick();
      chk("t1_last_valid", out_valid, 1);
      chk("t1_last_data", o1, 4);
      chk("t1_busy_hold", busy, 1);
      chk("t1_done_early", done, 0);
      tick();
      chk("t1_done", done, 1);
      chk("t1_busy_fall", busy, 0);
      tick();
      chk("t1_done_pulse", done, 0);
      chk("t1_ndone", n_done - d0, 1);
      chk("t1_count", q.size(), 4);
      for (int i = 0; i < 4; i++) chk_q("t1_out", i, i + 1, 10 * (i + 1), -(i + 1));

      // 2: three passes with random gaps, only final pass emits
      q.delete();
      start_job(8, 3);
      for (int p = 0; p < 3; p++) begin
         for (int c = 0; c < 8; c++) begin
            beat(10 * (p + 1), 10 * (p + 1), 10 * (p + 1));
            repeat ($urandom_range(0, 2)) tick();
         end
         if (p == 1) begin
            tick(); tick();
            chk("t2_no_partial", q.size(), 0);
         end
      end
      wait_done("t2_done");
      chk("t2_count", q.size(), 8);
      for (int i = 0; i < 8; i++) chk_q("t2_out", i, 60, 60, 60);

      // 3: saturation
      q.delete();
      start_job(2, 2);
      beat(32'h7FFF_FFFF, 32'h8000_0000, 5);
      beat(1, 2, 3);
      beat(1, -1, -7);
      beat(4, 5, 6);
      wait_done("t3_done");
      chk("t3_count", q.size(), 2);
      chk_q("t3_sat", 0, 32'h7FFF_FFFF, 32'h8000_0000, -2);
      chk_q("t3_plain", 1, 5, 7, 9);

      // 4: row_len=1 back-to-back, exercises forwarding
      q.delete();
      start_job(1, 4);
      repeat (4) beat(5, 5, 5);
      wait_done("t4_done");
      chk("t4_count", q.size(), 1);
      chk_q("t4_fwd", 0, 20, 20, 20);

      // 5: reset mid-job, then fresh job must not see stale buffer
      q.delete();
      start_job(2, 2);
      beat(100, 100, 100);
      beat(100, 100, 100);
      beat(1, 1, 1);
      d0 = n_done;
      rst = 1'b1;
      #2;
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_valid", out_valid, 0);
      chk("t5_rst_data", o1, 0);
      chk("t5_rst_done", done, 0);
      tick(); tick();
      rst = 1'b0;
      tick(); tick();
      chk("t5_no_done", n_done - d0, 0);
      start_job(2, 2);
      beat(3, 3, 3);
      beat(3, 3, 3);
      beat(4, 4, 4);
      beat(4, 4, 4);
      wait_done("t5_done");
      chk("t5_count", q.size(), 2);
      chk_q("t5_c0", 0, 7, 7, 7);
      chk_q("t5_c1", 1, 7, 7, 7);

      // 6: protocol errors
      q.delete(); e0 = n_err;
      in_valid = 1'b1; d1 = 9;
      tick(); tick();
      in_valid = 1'b0;
      tick(); tick();
      chk("t6_idle_err", n_err - e0, 2);
      chk("t6_idle_noout", q.size(), 0);
      e0 = n_err;
      start_job(0, 1);
      tick();
      chk("t6_len0_err", n_err - e0, 1);
      chk("t6_len0_busy", busy, 0);
      e0 = n_err;
      start_job(9, 1);
      tick();
      chk("t6_len9_err", n_err - e0, 1);
      chk("t6_len9_busy", busy, 0);
      e0 = n_err;
      start_job(2, 1);
      beat(1, 2, 3);
      start_job(1, 5);
      beat(4, 5, 6);
      wait_done("t6_busy_start_done");
      chk("t6_busy_start_noerr", n_err - e0, 0);
      chk("t6_busy_start_count", q.size(), 2);
      chk_q("t6_busy_start_out", 1, 4, 5, 6);

      // num_pass=0 behaves as a single pass
      q.delete();
      start_job(1, 0);
      beat(9, 8, 7);
      wait_done("t6_np0_done");
      chk("t6_np0_count", q.size(), 1);
      chk_q("t6_np0_out", 0, 9, 8, 7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/psum_accum.md
Name: psum_accum

Overview:
- Sits directly downstream of the 4-row conv group array.
- Consumes the three conv_data streams and conv_valid, and accumulates them per pixel column across cfg_num_pass input-channel-group passes.
- Emits the final sums on the last pass.
- Replaces the unused partial-reset path: pass 0 overwrites the buffer, later passes add into it.

Parameters:
- DATA_W, 32, width of in/out data; equals the shared DATA_INTER_WIDTH define.
- DEPTH, 224, maximum columns per pass (buffer entries).
- ADDR_W, 8, column address width; must satisfy 2^ADDR_W >= DEPTH.
- PASS_W, 8, width of the pass counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- start  in  1  one-cycle pulse that launches a job; sampled only in IDLE.
- cfg_row_len  in  ADDR_W+1  beats per pass, valid range 1..DEPTH; latched at start.
- cfg_num_pass  in  PASS_W  passes per job; 0 is treated as 1; latched at start.
- in_data_1..in_data_3  in  DATA_W each  signed conv partial sums, one per output row.
- in_valid  in  1  beat qualifier; no backpressure exists.
- out_data_1..out_data_3  out  DATA_W each  final signed sums.
- out_valid  out  1  final-pass beat qualifier.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at job end.
- err  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Buffer contents are don't-care.
- States:
  - IDLE: start with legal cfg -> ACCUM. cfg_row_len=0 or >DEPTH -> err pulse, stay IDLE.
  - ACCUM: counts col (0..row_len-1) and pass (0..num_pass-1). The last beat of the last pass -> DRAIN.
  - DRAIN: waits 2 cycles for the pipeline to empty, then pulses done for 1 cycle -> IDLE.
- Counters per beat: each in_valid beat in ACCUM advances col; col wraps to 0 at row_len and pass increments.
- Pipeline, 2 stages:
  - S0 (beat cycle t): issue buffer read at col; register the data, col and flags.
  - S1 (t+1): compute. Pass 0: new = in. Otherwise: new = rd + in, saturated per lane. Write new at col.
  - Final-pass results are registered to out_data_*, with out_valid at t+2.
  - Non-final passes: out_valid stays 0 and out_data holds its last value.
- Saturation: signed DATA_W add per lane; clamp to 2^(DATA_W-1)-1 on positive overflow and to -2^(DATA_W-1) on negative overflow.
- Hazard: when row_len=1 with back-to-back beats, S0 reads the address S1 is writing. S1's new value must be forwarded in place of the stale read. The general rule: forward whenever S0 addr == S1 addr and S1 is writing.
- Buffer: three DATA_W-wide lanes sharing one address, or one 3*DATA_W-wide RAM. 1-cycle synchronous read, write-first not required because forwarding covers it.
- Boundary conditions:
  - in_valid in IDLE or DRAIN: beat dropped, err pulse.
  - start while busy: ignored, no err.
  - Gaps in in_valid are allowed anywhere.
  - rst mid-job: immediate return to IDLE, no done pulse. The next job's pass 0 overwrites the stale buffer.
  - num_pass=1: every beat is final; no read-add is needed (rd is ignored).

Decomposition:
- Shared define header: DATA_INTER_WIDTH (reused as DATA_W default), and the state encodings IDLE/ACCUM/DRAIN.
- One sub-module, psum_buf: a simple dual-port RAM, 3*DATA_W wide × DEPTH, 1-cycle synchronous read, inferable as block RAM.
- Saturating add is a local function; three lane instances live in psum_accum.

Test Plan (DEPTH=8, DATA_W=32 in sim):
1. row_len=4, num_pass=1; beats lane1=1,2,3,4 (lane2=lane1*10, lane3=-lane1) -> out_valid at t+2 for each beat with identical values; done 3 cycles after the last beat; busy falls with done.
2. row_len=8, num_pass=3; every beat per pass = 10, then 20, then 30 on all lanes, with random gaps -> 8 outputs of 60 on the final pass only; no out_valid in passes 0-1.
3. Saturation, num_pass=2, row_len=2:
   - lane1 0x7FFFFFFF then +1 -> 0x7FFFFFFF.
   - lane2 0x80000000 then -1 -> 0x80000000.
   - lane3 5 then -7 -> -2.
4. row_len=1, num_pass=4; back-to-back in_valid, value 5 on all lanes -> single output of 20 (checks the forward path).
5. Reset during pass 1 of a num_pass=2 job, then a new job (row_len=2, num_pass=2, values 3 then 4) -> all outputs 0 during reset, no done; new results are 7, with no stale data.
6. Errors:
   - in_valid high for 2 cycles in IDLE -> two err pulses, no out_valid.
   - start with cfg_row_len=0 -> err, busy stays 0.
   - start during ACCUM -> ignored, job completes normally.
